// File: rtl/wallace_csa_reducer_pkg.sv
// Shared sizing constants and constant functions that describe the Wallace
// reduction tree: how many rows survive each 3:2 level and where the stages split.
package wallace_pkg;

  localparam int WIDTH_DEF  = 32;
  localparam int TAG_W_DEF  = 4;
  localparam int PROD_W     = 2 * WIDTH_DEF;
  localparam int NUM_LEVELS = 8;
  localparam int PIPE_LAT   = 4;

  // Every full triplet becomes two rows; leftover rows pass through.
  function automatic int next_rows(input int n);
    return 2 * (n / 3) + (n % 3);
  endfunction

  // Row-count table: rows present after level lvl when starting from n0 rows.
  function automatic int rows_at_level(input int n0, input int lvl);
    int n;
    n = n0;
    for (int i = 0; i < lvl; i++) n = next_rows(n);
    return n;
  endfunction

  function automatic int num_levels(input int n0);
    int n;
    int l;
    n = n0;
    l = 0;
    while (n > 2) begin
      n = next_rows(n);
      l++;
    end
    return l;
  endfunction

  // Levels are split evenly across the stages; the last stage ends on the last level.
  function automatic bit is_stage_end(input int lvl, input int levels);
    for (int k = 1; k <= PIPE_LAT; k++) begin
      if (((k * levels + PIPE_LAT - 1) / PIPE_LAT) == lvl) return 1'b1;
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/wallace_csa_reducer_csa_row.sv
// Vector 3:2 compressor: bitwise full adders, carry vector returned already
// aligned one place left so the next level simply adds it.
module csa_row
  import wallace_pkg::*;
#(
  parameter int W = PROD_W
) (
  input  logic [W-1:0] i_x,
  input  logic [W-1:0] i_y,
  input  logic [W-1:0] i_z,
  output logic [W-1:0] o_sum,
  output logic [W-1:0] o_carry
);

  assign o_sum   = i_x ^ i_y ^ i_z;
  assign o_carry = ((i_x & i_y) | (i_x & i_z) | (i_y & i_z)) << 1;

endmodule

// File: rtl/wallace_csa_reducer.sv
// Pipelined partial-product generation and carry-save reduction to a sum/carry
// pair, with a global-stall valid/ready pipeline and a tag carried alongside.
module wallace_csa_reducer
  import wallace_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_sum,
  output logic [2*WIDTH-1:0] out_carry,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int PW     = 2 * WIDTH;
  localparam int LEVELS = (WIDTH == WIDTH_DEF) ? NUM_LEVELS : num_levels(WIDTH);

  // w_lvl: combinational result of each level; w_src: same rows after the
  // optional stage register, i.e. what the following level consumes.
  logic [PW-1:0]       w_lvl [LEVELS+1][WIDTH];
  logic [PW-1:0]       w_src [LEVELS+1][WIDTH];
  logic                w_stall;
  logic [PIPE_LAT-1:0] r_vld;
  logic [TAG_W-1:0]    r_tag [PIPE_LAT];

  genvar gl, gi;

  assign w_stall  = r_vld[PIPE_LAT-1] & ~out_ready;
  assign in_ready = ~w_stall;

  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_pp
      assign w_lvl[0][gi] = ({{WIDTH{1'b0}}, in_a} & {PW{in_b[gi]}}) << gi;
    end

    for (gl = 1; gl <= LEVELS; gl++) begin : g_level
      localparam int N_IN  = rows_at_level(WIDTH, gl - 1);
      localparam int N_TRI = N_IN / 3;
      localparam int N_OUT = rows_at_level(WIDTH, gl);
      for (gi = 0; gi < N_TRI; gi++) begin : g_csa
        csa_row #(.W(PW)) u_csa (
          .i_x    (w_src[gl-1][3*gi]),
          .i_y    (w_src[gl-1][3*gi+1]),
          .i_z    (w_src[gl-1][3*gi+2]),
          .o_sum  (w_lvl[gl][2*gi]),
          .o_carry(w_lvl[gl][2*gi+1])
        );
      end
      for (gi = 0; gi < N_IN - 3 * N_TRI; gi++) begin : g_pass
        assign w_lvl[gl][2*N_TRI+gi] = w_src[gl-1][3*N_TRI+gi];
      end
      for (gi = N_OUT; gi < WIDTH; gi++) begin : g_zero
        assign w_lvl[gl][gi] = '0;
      end
    end

    for (gl = 0; gl <= LEVELS; gl++) begin : g_stage
      if (gl > 0 && is_stage_end(gl, LEVELS)) begin : g_reg
        localparam int N_LIVE = rows_at_level(WIDTH, gl);
        for (gi = 0; gi < WIDTH; gi++) begin : g_row
          if (gi < N_LIVE) begin : g_live
            logic [PW-1:0] r_row;
            always_ff @(posedge clk) begin
              if (rst) begin
                r_row <= '0;
              end else if (!w_stall) begin
                r_row <= w_lvl[gl][gi];
              end
            end
            assign w_src[gl][gi] = r_row;
          end else begin : g_dead
            assign w_src[gl][gi] = '0;
          end
        end
      end else begin : g_wire
        for (gi = 0; gi < WIDTH; gi++) begin : g_row
          assign w_src[gl][gi] = w_lvl[gl][gi];
        end
      end
    end
  endgenerate

  // Bubbles advance with the data; only a blocked output freezes the pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      for (int k = 0; k < PIPE_LAT; k++) r_tag[k] <= '0;
    end else if (!w_stall) begin
      r_vld    <= {r_vld[PIPE_LAT-2:0], in_valid};
      r_tag[0] <= in_tag;
      for (int k = 1; k < PIPE_LAT; k++) r_tag[k] <= r_tag[k-1];
    end
  end

  assign out_valid = r_vld[PIPE_LAT-1];
  assign out_tag   = r_tag[PIPE_LAT-1];
  assign out_sum   = w_src[LEVELS][0];
  assign out_carry = w_src[LEVELS][1];

endmodule

// File: tb/tb_wallace_csa_reducer.sv
// Scenario bench for wallace_csa_reducer: queue-based scoreboard on
// (out_sum + out_carry, out_tag) plus per-scenario timing and stability checks.
module tb_wallace_csa_reducer;

  localparam int WIDTH = 32;
  localparam int TAG_W = 4;

  typedef struct {
    logic [63:0] prod;
    logic [3:0]  tag;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_sum;
  logic [63:0] out_carry;
  logic [3:0]  out_tag;

  exp_t sb[$];
  int   pop_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_lat = -1;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  wallace_csa_reducer #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_carry(out_carry),
    .out_tag  (out_tag)
  );

  // Output monitor: an output handshake pops the scoreboard head.
  initial begin
    exp_t        e;
    logic [63:0] got;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && out_valid && out_ready) begin
        got = out_sum + out_carry;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output got=%h tag=%0d required=no output", got, out_tag);
        end else begin
          e = sb.pop_front();
          last_lat = cyc - e.cyc;
          pop_cyc.push_back(cyc);
          if (got !== e.prod) begin
            errors++;
            $display("FAIL product got=%h required=%h", got, e.prod);
          end
          checks++;
          if (out_tag !== e.tag) begin
            errors++;
            $display("FAIL tag got=%0d required=%0d", out_tag, e.tag);
          end
          checks++;
          if (out_carry[0] !== 1'b0) begin
            errors++;
            $display("FAIL carry_bit0 got=%b required=0", out_carry[0]);
          end
          $display("TXN tag=%0d sum+carry=%h expected=%h lat=%0d", out_tag, got, e.prod, last_lat);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] t, input bit ordy, input logic [63:0] expv,
                       output bit acc);
    exp_t e;
    @(negedge clk);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_tag    = t;
    out_ready = ordy;
    #1;
    acc = v && in_ready;
    if (acc) begin
      e.prod = expv;
      e.tag  = t;
      e.cyc  = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic idle(input bit ordy);
    bit acc;
    drive(1'b0, $urandom, $urandom, 4'($urandom), ordy, 64'd0, acc);
  endtask

  task automatic wait_drain(input int maxc);
    int n;
    n = 0;
    while (sb.size() != 0 && n < maxc) begin
      idle(1'b1);
      n++;
    end
    idle(1'b1);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b required=0", out_valid); end
    checks++;
    if (out_sum !== 64'd0) begin errors++; $display("FAIL reset_sum got=%h required=0", out_sum); end
    checks++;
    if (out_carry !== 64'd0) begin errors++; $display("FAIL reset_carry got=%h required=0", out_carry); end
    checks++;
    if (out_tag !== 4'd0) begin errors++; $display("FAIL reset_tag got=%0d required=0", out_tag); end
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b required=1", in_ready); end
  endtask

  task automatic test_basic();
    bit acc;
    drive(1'b1, 32'h01010101, 32'h01010101, 4'd3, 1'b1, 64'h0001020304030201, acc);
    checks++;
    if (acc !== 1'b1) begin errors++; $display("FAIL basic_accept got=%b required=1", acc); end
    wait_drain(20);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL basic_drain got=%0d pending required=0", sb.size()); end
    checks++;
    if (last_lat != 4) begin errors++; $display("FAIL basic_latency got=%0d required=4", last_lat); end
  endtask

  task automatic test_extremes();
    bit acc;
    drive(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd9, 1'b1, 64'hFFFFFFFE00000001, acc);
    drive(1'b1, 32'h00000000, 32'hDEADBEEF, 4'd10, 1'b1, 64'h0, acc);
    drive(1'b1, 32'h80000000, 32'h00000002, 4'd11, 1'b1, 64'h0000000100000000, acc);
    wait_drain(20);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL extremes_drain got=%0d pending required=0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    bit          acc;
    logic [31:0] a, b;
    pop_cyc.delete();
    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      b = $urandom;
      drive(1'b1, a, b, 4'(i), 1'b1, {32'd0, a} * {32'd0, b}, acc);
      checks++;
      if (acc !== 1'b1) begin errors++; $display("FAIL b2b_accept[%0d] got=%b required=1", i, acc); end
    end
    wait_drain(30);
    checks++;
    if (pop_cyc.size() != 16) begin
      errors++;
      $display("FAIL b2b_count got=%0d required=16", pop_cyc.size());
    end else begin
      for (int i = 1; i < 16; i++) begin
        checks++;
        if (pop_cyc[i] != pop_cyc[0] + i) begin
          errors++;
          $display("FAIL b2b_spacing[%0d] got=%0d required=%0d", i, pop_cyc[i], pop_cyc[0] + i);
        end
      end
    end
    checks++;
    if (last_lat != 4) begin errors++; $display("FAIL b2b_latency got=%0d required=4", last_lat); end
  endtask

  task automatic test_backpressure();
    bit          acc;
    int          n;
    logic [31:0] a, b, ha, hb;
    logic [63:0] s_sum, s_carry;
    logic [3:0]  s_tag;
    n = 0;
    do begin
      a = $urandom;
      b = $urandom;
      drive(1'b1, a, b, 4'(n), 1'b1, {32'd0, a} * {32'd0, b}, acc);
      n++;
    end while (!out_valid && n < 10);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_fill got=%b required=1", out_valid); end
    ha = $urandom;
    hb = $urandom;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, ha, hb, 4'd14, 1'b0, {32'd0, ha} * {32'd0, hb}, acc);
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got=%b required=0", k, in_ready); end
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got=%b required=1", k, out_valid); end
      if (k == 0) begin
        s_sum   = out_sum;
        s_carry = out_carry;
        s_tag   = out_tag;
      end else begin
        checks++;
        if (out_sum !== s_sum || out_carry !== s_carry || out_tag !== s_tag) begin
          errors++;
          $display("FAIL bp_hold[%0d] got=%h/%h/%0d required=%h/%h/%0d",
                   k, out_sum, out_carry, out_tag, s_sum, s_carry, s_tag);
        end
      end
    end
    n = 0;
    do begin
      drive(1'b1, ha, hb, 4'd14, 1'b1, {32'd0, ha} * {32'd0, hb}, acc);
      n++;
    end while (!acc && n < 10);
    checks++;
    if (acc !== 1'b1) begin errors++; $display("FAIL bp_resume_accept got=%b required=1", acc); end
    wait_drain(30);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL bp_drain got=%0d pending required=0", sb.size()); end
  endtask

  task automatic test_reset_midflight();
    bit          acc;
    logic [31:0] a, b;
    repeat (5) idle(1'b1);
    for (int i = 0; i < 3; i++) begin
      a = $urandom;
      b = $urandom;
      drive(1'b1, a, b, 4'(i + 5), 1'b1, {32'd0, a} * {32'd0, b}, acc);
    end
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (out_sum !== 64'd0 || out_carry !== 64'd0 || out_tag !== 4'd0) begin
      errors++;
      $display("FAIL midrst_data got=%h/%h/%0d required=0/0/0", out_sum, out_carry, out_tag);
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got=%b required=1", in_ready); end
    for (int k = 0; k < 6; k++) begin
      idle(1'b1);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid[%0d] got=%b required=0", k, out_valid); end
    end
    a = $urandom;
    b = $urandom;
    drive(1'b1, a, b, 4'd12, 1'b1, {32'd0, a} * {32'd0, b}, acc);
    wait_drain(20);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL midrst_drain got=%0d pending required=0", sb.size()); end
    checks++;
    if (last_lat != 4) begin errors++; $display("FAIL midrst_latency got=%0d required=4", last_lat); end
  endtask

  task automatic test_soak();
    bit          acc;
    bit          v, ordy;
    int          done, n;
    logic [31:0] a, b;
    logic [3:0]  t;
    done = 0;
    n    = 0;
    a = $urandom;
    b = $urandom;
    t = 4'($urandom);
    while (done < 10000 && n < 60000) begin
      v    = ($urandom_range(3) != 0);
      ordy = ($urandom_range(3) != 0);
      drive(v, a, b, t, ordy, {32'd0, a} * {32'd0, b}, acc);
      if (acc) begin
        done++;
        a = $urandom;
        b = $urandom;
        t = 4'($urandom);
      end
      n++;
    end
    checks++;
    if (done != 10000) begin errors++; $display("FAIL soak_count got=%0d required=10000", done); end
    wait_drain(50);
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL soak_drain got=%0d pending required=0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_soak();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
